// File: rtl/count_seq_checker.sv
// Far-end monitor for a free-running counter bus: locks onto a +1 sequence,
// then pulses and counts (saturating) every discontinuity seen while locked.
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_vld,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_prev, w_prev_nxt;
  logic [GOOD_W-1:0] r_good, w_good_nxt;
  logic [BAD_W-1:0]  r_bad, w_bad_nxt;
  logic              r_err_pulse, w_err_pulse_nxt;
  logic [ERR_W-1:0]  r_err_count, w_err_count_nxt;

  logic [WIDTH-1:0]  w_prev_inc;
  logic [GOOD_W-1:0] w_good_inc;
  logic [BAD_W-1:0]  w_bad_inc;
  logic              w_match;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign w_prev_inc = r_prev + WIDTH'(1);
  assign w_good_inc = r_good + GOOD_W'(1);
  assign w_bad_inc  = r_bad + BAD_W'(1);
  assign w_match    = (cnt_in == w_prev_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prev      <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_prev_nxt;
      r_good      <= w_good_nxt;
      r_bad       <= w_bad_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  // The checker always resyncs prev to the received value, so one bad
  // sample costs one error rather than a run of them.
  always_comb begin
    w_state_nxt     = r_state;
    w_prev_nxt      = r_prev;
    w_good_nxt      = r_good;
    w_bad_nxt       = r_bad;
    w_err_pulse_nxt = 1'b0;
    w_err_count_nxt = r_err_count;
    if (cnt_vld) begin
      w_prev_nxt = cnt_in;
      case (r_state)
        ST_IDLE: begin
          w_good_nxt  = '0;
          w_state_nxt = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (w_match) begin
            if (w_good_inc == GOOD_W'(LOCK_CNT)) begin
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
              w_state_nxt = ST_LOCKED;
            end else begin
              w_good_nxt = w_good_inc;
            end
          end else begin
            w_good_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            w_bad_nxt = '0;
          end else begin
            w_err_pulse_nxt = 1'b1;
            w_err_count_nxt = sat_inc(r_err_count);
            if (w_bad_inc == BAD_W'(LOSS_CNT)) begin
              w_bad_nxt   = '0;
              w_good_nxt  = '0;
              w_state_nxt = ST_SEARCH;
            end else begin
              w_bad_nxt = w_bad_inc;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign locked    = (r_state == ST_LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign expected  = (r_state == ST_IDLE) ? '0 : w_prev_inc;

endmodule
